rojobot_host_if: RTL and testbench

System-side register slave for the Rojobot 3.1 BOT block, the counterpart of its PicoBlaze register interface. Consumes the BOT's synchronized outputs (LocX, LocY, BotInfo, Sensors) and toggle-style upd_sysregs flag, and captures each update into a coherent snapshot for the host CPU. Raises a maskable interrupt on each update and drives the BOT's MotCtl and BotConfig inputs from host-writable registers. Includes a motor-command watchdog.

---
 rtl/rojobot_host_if.sv | 165 ++++++++++++++++
 tb/tb_rojobot_host_if.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rojobot_host_if.sv
// Host-side register slave for the Rojobot BOT block: captures each BOT
// system-register update into a coherent snapshot, raises a maskable
// interrupt, and drives MotCtl/BotConfig with a motor-command watchdog.
module rojobot_host_if #(
  parameter logic [7:0]  DEFAULT_MOTCTL = 8'h00,
  parameter logic [7:0]  DEFAULT_CONFIG = 8'h00,
  parameter int unsigned WDOG_W         = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic [7:0]  LocX,
  input  logic [7:0]  LocY,
  input  logic [7:0]  BotInfo,
  input  logic [7:0]  Sensors,
  input  logic        upd_sysregs,
  output logic [7:0]  MotCtl,
  output logic [7:0]  BotConfig,
  output logic        irq
);

  typedef enum logic [2:0] {
    A_SNAP   = 3'd0,
    A_STATUS = 3'd1,
    A_MOTCTL = 3'd2,
    A_BOTCFG = 3'd3,
    A_LIVE   = 3'd4,
    A_WDOG   = 3'd5
  } reg_addr_e;

  logic              r_upd_prev;
  logic [31:0]       r_snap;
  logic [15:0]       r_upd_count;
  logic              r_pending, r_overrun, r_irq_en, r_wdog_trip;
  logic [WDOG_W-1:0] r_timeout, r_wdog_cnt;
  logic [7:0]        r_motctl, r_botcfg;
  logic [31:0]       r_rdata;
  logic              r_ready, r_irq;

  logic              w_upd_evt, w_wr, w_rd;
  logic              w_wr_status, w_wr_motctl, w_wr_botcfg, w_wr_wdog;
  logic              w_clr_pending;
  logic [31:0]       w_live;
  logic [31:0]       w_snap_nxt, w_rdata_nxt;
  logic [15:0]       w_count_nxt;
  logic              w_pending_nxt, w_overrun_nxt, w_irq_en_nxt, w_trip_nxt;
  logic [WDOG_W-1:0] w_timeout_nxt, w_cnt_nxt;
  logic [7:0]        w_motctl_nxt, w_botcfg_nxt;
  logic              w_unused;

  assign w_upd_evt     = upd_sysregs ^ r_upd_prev;
  assign w_wr          = bus_sel & bus_we;
  assign w_rd          = bus_sel & ~bus_we;
  assign w_wr_status   = w_wr && (bus_addr == A_STATUS);
  assign w_wr_motctl   = w_wr && (bus_addr == A_MOTCTL);
  assign w_wr_botcfg   = w_wr && (bus_addr == A_BOTCFG);
  assign w_wr_wdog     = w_wr && (bus_addr == A_WDOG);
  assign w_clr_pending = w_wr_status & bus_wdata[0];
  assign w_live        = {LocX, LocY, BotInfo, Sensors};
  assign w_unused      = ^bus_wdata;

  // Next-state for capture, status, watchdog and read-data mux
  always_comb begin
    w_snap_nxt    = r_snap;
    w_count_nxt   = r_upd_count;
    w_pending_nxt = r_pending;
    w_overrun_nxt = r_overrun;
    w_irq_en_nxt  = r_irq_en;
    w_trip_nxt    = r_wdog_trip;
    w_timeout_nxt = r_timeout;
    w_cnt_nxt     = r_wdog_cnt;
    w_motctl_nxt  = r_motctl;
    w_botcfg_nxt  = r_botcfg;
    w_rdata_nxt   = r_rdata;

    // Clears are applied first so that same-cycle sets take priority
    if (w_clr_pending)                   w_pending_nxt = 1'b0;
    if (w_wr_status && bus_wdata[1])     w_overrun_nxt = 1'b0;
    if (w_wr_status && bus_wdata[3])     w_trip_nxt    = 1'b0;
    if (w_wr_status)                     w_irq_en_nxt  = bus_wdata[2];
    if (w_wr_botcfg)                     w_botcfg_nxt  = bus_wdata[7:0];

    if (w_upd_evt) begin
      w_snap_nxt    = w_live;
      w_count_nxt   = r_upd_count + 16'd1;
      w_pending_nxt = 1'b1;
      if (r_pending && !w_clr_pending) w_overrun_nxt = 1'b1;
    end

    // A reload in the expiry cycle pre-empts the trip
    if (w_wr_motctl) w_motctl_nxt = bus_wdata[7:0];
    if (w_wr_wdog) begin
      w_timeout_nxt = bus_wdata[WDOG_W-1:0];
      w_cnt_nxt     = bus_wdata[WDOG_W-1:0];
    end else if (w_wr_motctl) begin
      w_cnt_nxt = r_timeout;
    end else if (r_wdog_cnt != '0) begin
      w_cnt_nxt = r_wdog_cnt - WDOG_W'(1);
      if (r_wdog_cnt == WDOG_W'(1)) begin
        w_motctl_nxt = 8'h00;
        w_trip_nxt   = 1'b1;
      end
    end

    if (w_rd) begin
      case (bus_addr)
        A_SNAP:   w_rdata_nxt = r_snap;
        A_STATUS: w_rdata_nxt = {r_upd_count, 12'h000, r_wdog_trip, r_irq_en, r_overrun, r_pending};
        A_MOTCTL: w_rdata_nxt = {24'h0, r_motctl};
        A_BOTCFG: w_rdata_nxt = {24'h0, r_botcfg};
        A_LIVE:   w_rdata_nxt = w_live;
        A_WDOG:   w_rdata_nxt = 32'(r_timeout);
        default:  w_rdata_nxt = '0;
      endcase
    end
  end

  // State registers; irq is registered from the next-state terms so it
  // rises together with pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_upd_prev  <= 1'b0;
      r_snap      <= '0;
      r_upd_count <= '0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_irq_en    <= 1'b0;
      r_wdog_trip <= 1'b0;
      r_timeout   <= '0;
      r_wdog_cnt  <= '0;
      r_motctl    <= DEFAULT_MOTCTL;
      r_botcfg    <= DEFAULT_CONFIG;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_upd_prev  <= upd_sysregs;
      r_snap      <= w_snap_nxt;
      r_upd_count <= w_count_nxt;
      r_pending   <= w_pending_nxt;
      r_overrun   <= w_overrun_nxt;
      r_irq_en    <= w_irq_en_nxt;
      r_wdog_trip <= w_trip_nxt;
      r_timeout   <= w_timeout_nxt;
      r_wdog_cnt  <= w_cnt_nxt;
      r_motctl    <= w_motctl_nxt;
      r_botcfg    <= w_botcfg_nxt;
      r_rdata     <= w_rdata_nxt;
      r_ready     <= bus_sel;
      r_irq       <= w_pending_nxt & w_irq_en_nxt;
    end
  end

  assign bus_rdata = r_rdata;
  assign bus_ready = r_ready;
  assign MotCtl    = r_motctl;
  assign BotConfig = r_botcfg;
  assign irq       = r_irq;

endmodule

// File: tb/tb_rojobot_host_if.sv
// Directed bench for rojobot_host_if: reads go through an expected-value
// queue popped when bus_ready returns the data.
module tb_rojobot_host_if;

  logic        clk, reset;
  logic        bus_sel, bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic [7:0]  LocX, LocY, BotInfo, Sensors;
  logic        upd_sysregs;
  logic [7:0]  MotCtl, BotConfig;
  logic        irq;

  rojobot_host_if #(
    .DEFAULT_MOTCTL(8'h5A),
    .DEFAULT_CONFIG(8'h00),
    .WDOG_W(24)
  ) dut (
    .clk(clk), .reset(reset),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .LocX(LocX), .LocY(LocY), .BotInfo(BotInfo), .Sensors(Sensors),
    .upd_sysregs(upd_sysregs),
    .MotCtl(MotCtl), .BotConfig(BotConfig), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_t;

  rd_t         rd_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_count = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge and span exactly one cycle
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    rd_t item;
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    rd_q.push_back('{tag, exp});
    @(negedge clk);
    bus_sel = 1'b0;
    check({tag, "_ready"}, {31'h0, bus_ready}, 32'h1);
    item = rd_q.pop_front();
    check(item.tag, bus_rdata, item.exp);
  endtask

  task automatic toggle();
    upd_sysregs = ~upd_sysregs;
    exp_count++;
    @(negedge clk);
  endtask

  task automatic set_live(input logic [31:0] v);
    {LocX, LocY, BotInfo, Sensors} = v;
  endtask

  function automatic logic [31:0] st(input logic [3:0] bits);
    return {exp_count, 12'h000, bits};
  endfunction

  initial begin
    reset = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    upd_sysregs = 1'b0; set_live(32'h0);
    repeat (2) @(negedge clk);
    check("rst_motctl", {24'h0, MotCtl}, 32'h5A);
    check("rst_botcfg", {24'h0, BotConfig}, 32'h00);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_ready", {31'h0, bus_ready}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    bus_read(3'd1, 32'h0, "rst_status");

    // Update capture with interrupt enabled
    set_live(32'h11223344);
    bus_write(3'd1, 32'h4);
    toggle();
    check("cap_irq", {31'h0, irq}, 32'h1);
    bus_read(3'd0, 32'h11223344, "cap_snap");
    bus_read(3'd1, 32'h0001_0005, "cap_status");
    bus_read(3'd4, 32'h11223344, "cap_live");
    bus_write(3'd1, 32'h1);
    check("clr_irq", {31'h0, irq}, 32'h0);

    // Overrun: two updates without clearing, newest snapshot wins
    set_live(32'h01020304);
    toggle();
    set_live(32'hAABBCCDD);
    toggle();
    bus_read(3'd0, 32'hAABBCCDD, "ovr_snap");
    bus_read(3'd1, st(4'b0011), "ovr_status");
    bus_write(3'd1, 32'h3);
    bus_read(3'd1, st(4'b0000), "ovr_cleared");
    toggle();
    // Update coincident with a pending W1C
    upd_sysregs = ~upd_sysregs;
    exp_count++;
    bus_write(3'd1, 32'h1);
    bus_read(3'd1, st(4'b0001), "evt_w1c_status");

    // Upper/lower register access
    bus_write(3'd3, 32'hFFFF_FF12);
    bus_read(3'd3, 32'h12, "botcfg_rd");
    check("botcfg_out", {24'h0, BotConfig}, 32'h12);
    bus_write(3'd6, 32'hDEAD_BEEF);
    bus_read(3'd6, 32'h0, "unmapped_rd");

    // Count wrap back to zero
    begin
      int n;
      n = 65536 - int'(exp_count);
      for (int i = 0; i < n; i++) toggle();
    end
    bus_read(3'd1, 32'h0000_0003, "wrap_status");
    bus_write(3'd1, 32'h3);

    // Watchdog expiry after exactly 10 cycles
    bus_write(3'd5, 32'd10);
    bus_read(3'd5, 32'd10, "wdog_rd");
    bus_write(3'd2, 32'hF7);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("wdog_hold%0d", i), {24'h0, MotCtl}, 32'hF7);
      @(negedge clk);
    end
    check("wdog_expired", {24'h0, MotCtl}, 32'h00);
    bus_read(3'd1, st(4'b1000), "wdog_trip");
    bus_write(3'd1, 32'h8);

    // MOTCTL write in the expiry cycle wins
    bus_write(3'd2, 32'h33);
    repeat (9) @(negedge clk);
    bus_write(3'd2, 32'h44);
    check("expiry_write_motctl", {24'h0, MotCtl}, 32'h44);
    bus_read(3'd1, st(4'b0000), "expiry_write_notrip");

    // Trip W1C in the expiry cycle loses
    bus_write(3'd5, 32'd3);
    bus_write(3'd2, 32'h11);
    repeat (2) @(negedge clk);
    bus_write(3'd1, 32'h8);
    bus_read(3'd1, st(4'b1000), "trip_beats_w1c");
    bus_write(3'd1, 32'h8);

    // Disabled watchdog never clears MotCtl
    bus_write(3'd5, 32'd0);
    bus_write(3'd2, 32'h66);
    repeat (30) @(negedge clk);
    check("wdog_off_motctl", {24'h0, MotCtl}, 32'h66);
    bus_read(3'd1, st(4'b0000), "wdog_off_status");

    // Asynchronous reset while pending and counting
    bus_write(3'd1, 32'h4);
    toggle();
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    bus_write(3'd5, 32'd50);
    bus_write(3'd2, 32'h77);
    bus_read(3'd2, 32'h77, "pre_rst_motctl");
    upd_sysregs = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_motctl", {24'h0, MotCtl}, 32'h5A);
    check("arst_botcfg", {24'h0, BotConfig}, 32'h00);
    check("arst_irq", {31'h0, irq}, 32'h0);
    check("arst_rdata", bus_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    @(negedge clk);
    bus_read(3'd1, 32'h0, "arst_status");
    bus_read(3'd0, 32'h0, "arst_snap");
    bus_read(3'd5, 32'h0, "arst_wdog");
    repeat (60) @(negedge clk);
    check("arst_no_trip", {24'h0, MotCtl}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
